// File: rtl/oc_pkg.sv
// Shared definitions for the over-current detect front end: FSM states,
// channel indices and default timing constants.
package oc_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRIPPED = 2'd1,
    LOCKOUT = 2'd2
  } oc_state_t;

  localparam int CH_A = 0;
  localparam int CH_B = 1;

  localparam int DEF_SAMPLE_DIV  = 1000;
  localparam int DEF_BLANK_CYC   = 200;
  localparam int DEF_TRIP_COUNT  = 8;
  localparam int DEF_CLEAR_COUNT = 16;
  localparam int DEF_MAX_TRIPS   = 3;
  localparam int DEF_LOCK_WIN    = 100000;

endpackage

// File: rtl/oc_chan_qual.sv
// One channel of sense conditioning: synchronizers, PWM blanking and the
// consecutive-sample run counter. OC_GLITCH_FILTER_EN adds a majority-of-3 filter.
module oc_chan_qual
  import oc_pkg::*;
#(
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter int TRIP_COUNT = DEF_TRIP_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  input  logic pwm,
  input  logic strobe,
  input  logic hold,
  output logic qualified,
  output logic raw_low
);

  localparam int BW = $clog2(BLANK_CYC + 2);
  localparam int RW = $clog2(TRIP_COUNT + 1);

  logic          sense_m, sense_s;
  logic          pwm_m, pwm_s, pwm_d;
  logic          sense_f;
  logic          sample;
  logic [BW-1:0] blank_cnt;
  logic [RW-1:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sense_m <= 1'b0;
      sense_s <= 1'b0;
      pwm_m   <= 1'b0;
      pwm_s   <= 1'b0;
      pwm_d   <= 1'b0;
    end else begin
      sense_m <= sense;
      sense_s <= sense_m;
      pwm_m   <= pwm;
      pwm_s   <= pwm_m;
      pwm_d   <= pwm_s;
    end
  end

`ifdef OC_GLITCH_FILTER_EN
  logic sense_h1, sense_h2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sense_h1 <= 1'b0;
      sense_h2 <= 1'b0;
    end else begin
      sense_h1 <= sense_s;
      sense_h2 <= sense_h1;
    end
  end

  assign sense_f = (sense_s & sense_h1) | (sense_s & sense_h2) | (sense_h1 & sense_h2);
`else
  assign sense_f = sense_s;
`endif

  // A fresh PWM turn-on reloads the window even if blanking is still running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_cnt <= '0;
    end else if (pwm_s && !pwm_d) begin
      blank_cnt <= BW'(BLANK_CYC);
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - BW'(1);
    end
  end

  assign sample = sense_f && (blank_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (hold) begin
      run_cnt <= '0;
    end else if (strobe) begin
      if (!sample) begin
        run_cnt <= '0;
      end else if (run_cnt != RW'(TRIP_COUNT)) begin
        run_cnt <= run_cnt + RW'(1);
      end
    end
  end

  // High on the strobe whose sample brings the run up to TRIP_COUNT.
  assign qualified = !hold && strobe && sample && (run_cnt >= RW'(TRIP_COUNT - 1));
  assign raw_low   = !sense_s;

endmodule

// File: rtl/oc_detect.sv
// Over-current detect top: sample strobe, ARMED/TRIPPED/LOCKOUT FSM, trip
// window and tally. Build option OC_GLITCH_FILTER_EN lives in oc_chan_qual.
module oc_detect
  import oc_pkg::*;
#(
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC,
  parameter int TRIP_COUNT  = DEF_TRIP_COUNT,
  parameter int CLEAR_COUNT = DEF_CLEAR_COUNT,
  parameter int MAX_TRIPS   = DEF_MAX_TRIPS,
  parameter int LOCK_WIN    = DEF_LOCK_WIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_a,
  input  logic       sense_b,
  input  logic       pwm_a,
  input  logic       pwm_b,
  input  logic       fault_clr,
  output logic       oc_req,
  output logic [1:0] oc_src,
  output logic [1:0] trip_cnt,
  output logic       lockout,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(CLEAR_COUNT + 2);
  localparam int WW = $clog2(LOCK_WIN + 1);

  oc_state_t     state;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] clr_cnt;
  logic [WW-1:0] win_cnt;
  logic          strobe;
  logic          hold;
  logic [1:0]    qual;
  logic [1:0]    raw_low;
  logic          win_expire;
  logic [1:0]    base_trips;
  logic [1:0]    next_trips;
  logic          lock_hit;

  assign state_dbg = state;
  assign strobe    = (div_cnt == DW'(SAMPLE_DIV - 1));
  assign hold      = (state != ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_cnt <= '0;
    else if (strobe) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  oc_chan_qual #(.BLANK_CYC(BLANK_CYC), .TRIP_COUNT(TRIP_COUNT)) u_chan_a (
    .clk(clk), .rst(rst), .sense(sense_a), .pwm(pwm_a), .strobe(strobe),
    .hold(hold), .qualified(qual[CH_A]), .raw_low(raw_low[CH_A])
  );

  oc_chan_qual #(.BLANK_CYC(BLANK_CYC), .TRIP_COUNT(TRIP_COUNT)) u_chan_b (
    .clk(clk), .rst(rst), .sense(sense_b), .pwm(pwm_b), .strobe(strobe),
    .hold(hold), .qualified(qual[CH_B]), .raw_low(raw_low[CH_B])
  );

  // A window expiry on the trip strobe clears the tally before the trip counts.
  assign win_expire = (win_cnt == WW'(LOCK_WIN - 1));

  always_comb begin
    base_trips = win_expire ? 2'd0 : trip_cnt;
    next_trips = (base_trips == 2'd3) ? 2'd3 : base_trips + 2'd1;
    lock_hit   = (int'(next_trips) >= MAX_TRIPS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARMED;
      oc_req   <= 1'b0;
      oc_src   <= 2'b00;
      trip_cnt <= 2'd0;
      lockout  <= 1'b0;
      clr_cnt  <= '0;
      win_cnt  <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (strobe) begin
            win_cnt <= win_expire ? '0 : win_cnt + WW'(1);
            if (win_expire) trip_cnt <= 2'd0;
            if (qual != 2'b00) begin
              oc_req   <= 1'b1;
              oc_src   <= qual;
              trip_cnt <= next_trips;
              win_cnt  <= '0;
              clr_cnt  <= '0;
              if (lock_hit) begin
                state   <= LOCKOUT;
                lockout <= 1'b1;
              end else begin
                state <= TRIPPED;
              end
            end
          end
        end
        TRIPPED: begin
          if (strobe) begin
            if (raw_low == 2'b11) begin
              if (clr_cnt == CW'(CLEAR_COUNT - 1)) begin
                state   <= ARMED;
                oc_req  <= 1'b0;
                clr_cnt <= '0;
                win_cnt <= '0;
              end else begin
                clr_cnt <= clr_cnt + CW'(1);
              end
            end else begin
              clr_cnt <= '0;
            end
          end
        end
        LOCKOUT: begin
          if (fault_clr) begin
            state    <= ARMED;
            oc_req   <= 1'b0;
            lockout  <= 1'b0;
            trip_cnt <= 2'd0;
            oc_src   <= 2'b00;
            clr_cnt  <= '0;
            win_cnt  <= '0;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: doc/oc_detect.md
Name: oc_detect

Overview:
- Front end of the over-current protection path.
- Samples two asynchronous current-sense comparator outputs, one per motor channel (A/B).
- Ignores samples during a blanking window after each PWM turn-on, and qualifies faults by consecutive over-threshold samples.
- Drives the level request that the shutdown/enable-gating block consumes. Repeated trips escalate to a latched lockout that only a manual clear can release.

Parameters:
- SAMPLE_DIV, 1000: clk cycles per sample strobe (10 us at 100 MHz); min 2.
- BLANK_CYC, 200: clk cycles of blanking after a rising edge of the synced PWM on that channel.
- TRIP_COUNT, 8: consecutive unblanked high samples on one channel needed to trip; min 1.
- CLEAR_COUNT, 16: consecutive strobes with both channels low needed to leave TRIPPED.
- MAX_TRIPS, 3: trips within the window that force LOCKOUT; min 1.
- LOCK_WIN, 100000: consecutive ARMED strobes without a trip that reset the trip tally.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- sense_a  in  1  channel A comparator output, async, high = over threshold
- sense_b  in  1  channel B comparator output, async
- pwm_a  in  1  channel A PWM drive, async to the sampling logic
- pwm_b  in  1  channel B PWM drive
- fault_clr  in  1  manual lockout clear, single-cycle pulse, synchronous to clk
- oc_req  out  1  over-current request to the shutdown block, level
- oc_src  out  2  {B,A} channels that caused the latest trip
- trip_cnt  out  2  trips in the current window, saturating
- lockout  out  1  high while in LOCKOUT

Behaviour:
- Reset values: all outputs 0, state ARMED, all counters 0, strobe divider 0.
- Input conditioning: sense_x and pwm_x each pass through a 2-flop synchronizer.
- Strobe: the divider counts 0..SAMPLE_DIV-1; strobe is high for one cycle at terminal count.
- Blanking: a per-channel down counter loads BLANK_CYC on a rising edge of synced pwm_x. While it is nonzero, that channel's samples read as low. A new PWM edge during blanking reloads the counter.
- Qualification: per-channel run counter; on each strobe, +1 if the sample is high, else cleared to 0. It saturates at TRIP_COUNT.
- States:
  - ARMED: when a run counter reaches TRIP_COUNT on a strobe, go to TRIPPED. oc_req rises on the following clock. oc_src latches the channels at threshold; 2'b11 if both reach it on the same strobe. trip_cnt increments.
  - TRIPPED: oc_req=1. Run counters are held at 0. The clear counter counts strobes where both raw synced senses are low (blanking ignored); any high sample resets it. At CLEAR_COUNT, go to ARMED, oc_req falls the next cycle, and the window counter resets.
  - LOCKOUT: entered instead of TRIPPED when the increment would make trip_cnt reach MAX_TRIPS. oc_req=1 and lockout=1 until fault_clr.
- Window: in ARMED, the window counter increments per strobe. At LOCK_WIN, trip_cnt clears to 0.
- fault_clr: acts only in LOCKOUT. It sends the state to ARMED and zeroes trip_cnt, oc_src, and all run, clear and window counters. oc_req and lockout fall the next cycle. It is ignored in ARMED and TRIPPED.
- Simultaneous events:
  - fault_clr coinciding with a qualifying sample in LOCKOUT: clear wins, and the sample is discarded.
  - Trip on the same strobe the window expires: the trip is counted after the clear, giving trip_cnt=1.
- Latency:
  - Sense edge to oc_req: 2 sync cycles, plus up to SAMPLE_DIV cycles to the first strobe, plus (TRIP_COUNT-1)×SAMPLE_DIV, plus 1 cycle.
  - Exact when aligned: with the first qualifying strobe at cycle t, oc_req is high at t+(TRIP_COUNT-1)×SAMPLE_DIV+1.
- Asserting rst mid-trip or in LOCKOUT returns every output to 0 immediately, without waiting for a clock.

Optional Feature:
- Macro: OC_GLITCH_FILTER_EN.
- Defined: a majority-of-3 filter over the last three synced sense_x values feeds the sampler. This adds 1 cycle of latency, and single-cycle comparator glitches never reach a sample.
- Undefined: the synced sense_x is sampled directly, and all latencies are as stated above.

Decomposition:
- Shared package oc_pkg holds:
  - the state enum (ARMED, TRIPPED, LOCKOUT);
  - the channel-index constants CH_A=0 and CH_B=1;
  - the default timing constants.
- One natural sub-module, oc_chan_qual, instanced twice. It contains the synchronizer, optional filter, blanking counter and run counter, and outputs "qualified" and "raw low".
- The FSM, divider, window and tally stay in the top level.

Test Plan (SAMPLE_DIV=4, BLANK_CYC=6, TRIP_COUNT=3, CLEAR_COUNT=4, MAX_TRIPS=3, LOCK_WIN=64):
- sense_a held high, no PWM edges -> oc_req=1 one cycle after the 3rd strobe, oc_src=01, trip_cnt=1.
- pwm_a rising edge every 8 cycles, sense_a high only for 5 cycles after each edge -> oc_req stays 0 indefinitely.
- sense_a and sense_b rise on the same cycle and are held -> oc_req=1, oc_src=11. Then both drop: oc_req=0 one cycle after the 4th low strobe.
- Three trip/clear cycles inside 64 strobes -> 3rd trip gives lockout=1 and oc_req=1. These stay high with senses low, until a fault_clr pulse; then both are 0 the next cycle and trip_cnt=0.
- One trip, then 64 quiet ARMED strobes -> trip_cnt returns to 0; a subsequent trip gives trip_cnt=1.
- rst pulse while in LOCKOUT, asserted between clock edges -> oc_req, lockout, oc_src and trip_cnt are 0 before the next clk edge.
